ysyx_24110006_scoreboard: RTL and testbench

Register-pending scoreboard for the in-order NPC pipeline. It tracks outstanding GPR writes from issue through EXU/LSU to writeback. It produces the decode-stage RAW stall that the pipeline uses in place of comparing rd fields stage by stage. Issue events mark a destination pending, writeback events release it, and decode queries rs1/rs2 against the pending table.

---
 rtl/ysyx_24110006_scoreboard.sv | 116 +++++++++++
 tb/tb_ysyx_24110006_scoreboard.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_scoreboard.sv
// Register-pending scoreboard: per-GPR in-flight write counters feeding the
// decode-stage RAW stall, plus a global in-flight count and sticky error flag.
module ysyx_24110006_scoreboard #(
  parameter int unsigned NR_REG = 32,
  parameter int unsigned CNT_W  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [6:0] i_op,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_wen,
  input  logic       i_issue,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  input  logic       i_flush,
  output logic       o_stall,
  output logic [3:0] o_inflight,
  output logic       o_idle,
  output logic       o_err
);

  localparam int unsigned TOT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [CNT_W-1:0] cnt_q [NR_REG];
  logic [CNT_W-1:0] cnt_d [NR_REG];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;

  logic inc_c, dec_c, use_rs1_c, use_rs2_c, pend1_c, pend2_c, sat_c, idle_c;

  // x0 and indices beyond the implemented register file are never tracked
  function automatic logic tracked(input logic [4:0] x);
    return (x != 5'd0) && (32'(x) < NR_REG);
  endfunction

  assign inc_c = i_issue && i_wen && tracked(i_rd);
  assign dec_c = i_wb_valid && tracked(i_wb_rd);

  always_comb begin
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    case (i_op)
      OP_BRANCH, OP_STORE, OP_OP: begin
        use_rs1_c = 1'b1;
        use_rs2_c = 1'b1;
      end
      OP_JALR, OP_OPIMM, OP_LOAD, OP_SYSTEM: use_rs1_c = 1'b1;
      default: ;
    endcase
  end

  // Queries read the registered table only; same-cycle writebacks are not bypassed
  assign pend1_c = tracked(i_rs1) && (cnt_q[i_rs1] != '0);
  assign pend2_c = tracked(i_rs2) && (cnt_q[i_rs2] != '0);
  assign sat_c   = i_wen && tracked(i_rd) && (cnt_q[i_rd] == CNT_MAX);
  assign o_stall = i_valid && ((use_rs1_c && pend1_c) || (use_rs2_c && pend2_c) || sat_c);

  always_comb begin
    idle_c = 1'b1;
    for (int unsigned r = 0; r < NR_REG; r++) begin
      if (cnt_q[r] != '0) idle_c = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    tot_d = tot_q;
    err_d = err_q;
    if (i_flush) begin
      for (int unsigned r = 0; r < NR_REG; r++) cnt_d[r] = '0;
      tot_d = '0;
    end else begin
      if (i_issue && o_stall) err_d = 1'b1;
      for (int unsigned r = 1; r < NR_REG; r++) begin
        if (inc_c && (i_rd == 5'(r)) && !(dec_c && (i_wb_rd == 5'(r)))) begin
          if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (dec_c && (i_wb_rd == 5'(r)) && !(inc_c && (i_rd == 5'(r)))) begin
          if (cnt_q[r] == '0) err_d = 1'b1;
          else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
      if (inc_c && !dec_c && (tot_q != TOT_MAX)) tot_d = tot_q + TOT_W'(1);
      if (dec_c && !inc_c && (tot_q != '0))      tot_d = tot_q - TOT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < NR_REG; r++) cnt_q[r] <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign o_inflight = tot_q;
  assign o_idle     = idle_c;
  assign o_err      = err_q;

endmodule

// File: tb/tb_ysyx_24110006_scoreboard.sv
// Bench for the register-pending scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a counter-array reference model.
module tb_ysyx_24110006_scoreboard;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
  localparam logic [6:0] FENCE = 7'b0001111, SYSTEM = 7'b1110011;

  logic       clock, reset;
  logic       valid, wen, issue, wb_valid, flush;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd, wb_rd;
  logic       stall, idle, err;
  logic [3:0] inflight;

  ysyx_24110006_scoreboard dut (
    .clock(clock), .reset(reset), .i_valid(valid), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_wen(wen), .i_issue(issue), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_flush(flush), .o_stall(stall), .o_inflight(inflight), .o_idle(idle), .o_err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: one integer pending count per architectural register
  int mcnt [32];
  int mtot = 0;
  bit merr = 0;

  logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] o);
    return o inside {JALR, OPIMM, LOAD, SYSTEM, BRANCH, STORE, OP};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] o);
    return o inside {BRANCH, STORE, OP};
  endfunction

  function automatic bit m_pend(input logic [4:0] x);
    return (x != 0) && (mcnt[x] != 0);
  endfunction

  function automatic bit m_stall();
    return valid && ((reads_rs1(op) && m_pend(rs1)) || (reads_rs2(op) && m_pend(rs2)) ||
                     (wen && rd != 0 && mcnt[rd] == 3));
  endfunction

  function automatic bit m_idle();
    foreach (mcnt[i]) if (mcnt[i] != 0) return 0;
    return 1;
  endfunction

  always @(posedge clock) begin : model
    bit inc, dec, st;
    if (reset) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mtot = 0;
      merr = 0;
    end else if (flush) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mtot = 0;
    end else begin
      st  = m_stall();
      inc = issue && wen && rd != 0;
      dec = wb_valid && wb_rd != 0;
      if (issue && st) merr = 1;
      if (!(inc && dec && rd == wb_rd)) begin
        if (inc) mcnt[rd] = (mcnt[rd] == 3) ? 3 : mcnt[rd] + 1;
        if (dec) begin
          if (mcnt[wb_rd] == 0) merr = 1;
          else mcnt[wb_rd] = mcnt[wb_rd] - 1;
        end
      end
      mtot = mtot + int'(inc) - int'(dec);
      if (mtot < 0) mtot = 0;
      if (mtot > 15) mtot = 15;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model_stall", int'(stall), int'(m_stall()));
      chk("model_inflight", int'(inflight), mtot);
      chk("model_idle", int'(idle), int'(m_idle()));
      chk("model_err", int'(err), int'(merr));
    end
  end

  task automatic clr();
    valid = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0; wen = 0;
    issue = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic dec_in(input logic v, input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic w, input logic is);
    valid = v; op = o; rs1 = a; rs2 = b; rd = d; wen = w; issue = is;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [4:0] pq [$];
    reset = 1;
    clr();
    nxt(); nxt();
    reset = 0;
    chk_en = 1;
    mid();
    chk("reset_idle", int'(idle), 1);
    chk("reset_inflight", int'(inflight), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_err", int'(err), 0);
    nxt();

    // RAW hold on x5 until its writeback is visible
    dec_in(1, OP, 1, 2, 5, 1, 1); nxt();
    dec_in(1, OP, 5, 7, 6, 1, 0); mid();
    chk("raw_stall", int'(stall), 1); nxt();
    nxt();
    wb_valid = 1; wb_rd = 5; mid();
    chk("raw_no_bypass", int'(stall), 1); nxt();
    wb_valid = 0; mid();
    chk("raw_release", int'(stall), 0);
    chk("raw_inflight", int'(inflight), 0); nxt();

    // Source-use decode with x5 pending
    dec_in(1, OPIMM, 0, 0, 5, 1, 1); nxt();
    dec_in(1, LUI, 5, 5, 5, 1, 0); mid();
    chk("lui_no_src", int'(stall), 0); nxt();
    dec_in(1, JAL, 5, 5, 1, 1, 0); mid();
    chk("jal_no_src", int'(stall), 0); nxt();
    dec_in(1, STORE, 5, 5, 0, 0, 0); mid();
    chk("store_src", int'(stall), 1); nxt();
    dec_in(1, OPIMM, 2, 5, 1, 1, 0); mid();
    chk("opimm_no_rs2", int'(stall), 0); nxt();
    clr(); wb_valid = 1; wb_rd = 5; nxt();
    clr();

    // Simultaneous issue and writeback on x3; x0 never tracked
    dec_in(1, OPIMM, 0, 0, 3, 1, 1); nxt();
    dec_in(1, OPIMM, 0, 0, 3, 1, 1); wb_valid = 1; wb_rd = 3; nxt();
    clr(); dec_in(1, OP, 3, 0, 0, 0, 0); mid();
    chk("simul_pending", int'(stall), 1);
    chk("simul_inflight", int'(inflight), 1); nxt();
    dec_in(1, OPIMM, 0, 0, 0, 1, 1); nxt();
    clr(); wb_valid = 1; wb_rd = 0; nxt();
    clr(); mid();
    chk("x0_inflight", int'(inflight), 1);
    chk("x0_no_err", int'(err), 0); nxt();
    wb_valid = 1; wb_rd = 3; nxt();
    clr();

    // Saturation of the x4 counter
    repeat (3) begin
      dec_in(1, OPIMM, 0, 0, 4, 1, 1); nxt();
    end
    dec_in(1, OPIMM, 0, 0, 4, 1, 0); mid();
    chk("sat_stall", int'(stall), 1);
    chk("sat_inflight", int'(inflight), 3); nxt();
    wb_valid = 1; wb_rd = 4; nxt();
    wb_valid = 0; mid();
    chk("sat_release", int'(stall), 0); nxt();
    clr(); wb_valid = 1; wb_rd = 4; nxt(); nxt();
    clr();

    // Flush clears the table; err is sticky across flush
    for (int d = 7; d <= 9; d++) begin
      dec_in(1, OPIMM, 0, 0, 5'(d), 1, 1); nxt();
    end
    clr(); mid();
    chk("pre_flush_inflight", int'(inflight), 3);
    chk("pre_flush_idle", int'(idle), 0); nxt();
    flush = 1; nxt();
    flush = 0; mid();
    chk("flush_idle", int'(idle), 1);
    chk("flush_inflight", int'(inflight), 0); nxt();
    wb_valid = 1; wb_rd = 9; nxt();
    clr(); mid();
    chk("err_set", int'(err), 1); nxt();
    flush = 1; nxt();
    flush = 0; mid();
    chk("err_after_flush", int'(err), 1); nxt();
    reset = 1; nxt();
    reset = 0; mid();
    chk("err_reset", int'(err), 0); nxt();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      clr();
      reset = ($urandom_range(0, 255) == 0);
      valid = ($urandom_range(0, 3) != 0);
      op    = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      rs1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wen   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      if (!flush) begin
        issue = valid && !m_stall() && ($urandom_range(0, 1) == 1);
        pq.delete();
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) pq.push_back(5'(r));
        if (pq.size() > 0 && $urandom_range(0, 1) == 1) begin
          wb_valid = 1;
          wb_rd = pq[$urandom_range(0, pq.size() - 1)];
        end else if ($urandom_range(0, 39) == 0) begin
          wb_valid = 1;
          wb_rd = 5'($urandom);
        end
      end
      nxt();
    end
    clr();
    reset = 0;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
